// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: funct3 encodings, AHB-Lite
// transfer constants, FSM states and lane helpers.
package mem_pkg;

  // RV load/store funct3 encodings; bit 2 selects zero extension on loads
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // Number of address bits that select a byte lane on a DATA_W-bit bus
  function automatic int unsigned lane_off_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  // Low address bits that must be zero for a naturally aligned access
  function automatic logic [2:0] size_mask(input logic [1:0] size);
    return 3'((4'd1 << size) - 4'd1);
  endfunction

endpackage

// File: rtl/mem_stage_ahb_if.sv
// AHB-Lite signal bundle between the memory stage (master) and the bus.
interface mem_stage_ahb_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic [ADDR_W-1:0] HADDR;
  logic [DATA_W-1:0] HWDATA;
  logic              HWRITE;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADY;
  logic              HRESP;

  modport master (
    output HADDR, HWDATA, HWRITE, HTRANS, HSIZE,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HWDATA, HWRITE, HTRANS, HSIZE,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/load_extract.sv
// Selects the addressed lane of a read beat and sign/zero extends it.
// Offsets that cross the top lane wrap around to lane 0.
module load_extract
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [DATA_W-1:0]               rdata,
  input  logic [lane_off_w(DATA_W)-1:0]   offset,
  input  logic [2:0]                      funct3,
  output logic [DATA_W-1:0]               data_c
);

  logic [DATA_W-1:0] rot;
  logic [DATA_W-1:0] hi_mask;
  logic              msb;
  int unsigned       nbits;

  // Rotate the addressed byte to lane 0, then extend from the access size
  always_comb begin
    rot     = DATA_W'({rdata, rdata} >> {offset, 3'b000});
    nbits   = 32'd8 << funct3[1:0];
    hi_mask = '0;
    data_c  = rot;
    unique case (funct3[1:0])
      2'd0:    msb = rot[7];
      2'd1:    msb = rot[15];
      2'd2:    msb = rot[31];
      default: msb = rot[DATA_W-1];
    endcase
    msb = msb & ~funct3[2];
    if (nbits < DATA_W) begin
      hi_mask = {DATA_W{1'b1}} << nbits;
      data_c  = (rot & ~hi_mask) | (msb ? hi_mask : '0);
    end
  end

endmodule

// File: rtl/mem_stage_ahb.sv
// Memory-access pipeline stage: one outstanding AHB-Lite load/store, lane
// steering, branch resolution and shadow-slot squash.
// Optional build macro MEM_MISALIGN_TRAP_EN: trap unaligned accesses at accept
// instead of issuing them with wrapped lane selection.
module mem_stage_ahb
  import mem_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        rd_i,
  input  logic [ADDR_W-1:0] address,
  input  logic [2:0]        funct3,
  input  logic              load,
  input  logic              store,
  input  logic [XLEN-1:0]   store_data,
  input  logic [XLEN-1:0]   alu_res,
  input  logic              write_back,
  input  logic              branch_flag_i,
  input  logic [XLEN-1:0]   branch_offset_i,
  input  logic [XLEN-1:0]   PC_i,
  mem_stage_ahb_if.master   ahb,
  output logic              out_valid,
  output logic [XLEN-1:0]   res,
  output logic [4:0]        rd_o,
  output logic              wb_en,
  output logic              take_branch,
  output logic [XLEN-1:0]   branch_offset_o,
  output logic [XLEN-1:0]   PC_o,
  output logic              fault
);

  localparam int unsigned OFF_W = lane_off_w(DATA_W);

  state_e            state_q, state_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [2:0]        hsize_q, hsize_d;
  logic              hwrite_q, hwrite_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic [2:0]        f3_q, f3_d;
  logic              wb_q, wb_d;
  logic [XLEN-1:0]   sdata_q, sdata_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [4:0]        rd_q, rd_d;
  logic              wb_en_q, wb_en_d;
  logic              take_branch_q, take_branch_d;
  logic [XLEN-1:0]   boff_q, boff_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              fault_q, fault_d;

  logic              accept_c;
  logic              misalign_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] ld_data_c;

  assign in_ready = (state_q == ST_IDLE);
  assign accept_c = in_valid & in_ready;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_c = |(address[2:0] & size_mask(funct3[1:0]));
`else
  assign misalign_c = 1'b0;
`endif

  // Replicate the low 2^size bytes of the store value across every lane
  always_comb begin
    unique case (f3_q[1:0])
      2'd0:    wdata_c = {(DATA_W/8){sdata_q[7:0]}};
      2'd1:    wdata_c = {(DATA_W/16){sdata_q[15:0]}};
      2'd2:    wdata_c = {(DATA_W/32){sdata_q[31:0]}};
      default: wdata_c = DATA_W'(sdata_q);
    endcase
  end

  load_extract #(.DATA_W(DATA_W)) u_load_extract (
    .rdata  (ahb.HRDATA),
    .offset (haddr_q[OFF_W-1:0]),
    .funct3 (f3_q),
    .data_c (ld_data_c)
  );

  // Next-state and registered-output logic for the IDLE/ADDR/DATA sequencer
  always_comb begin
    state_d       = state_q;
    htrans_d      = htrans_q;
    haddr_d       = haddr_q;
    hsize_d       = hsize_q;
    hwrite_d      = hwrite_q;
    hwdata_d      = hwdata_q;
    f3_d          = f3_q;
    wb_d          = wb_q;
    sdata_d       = sdata_q;
    res_d         = res_q;
    rd_d          = rd_q;
    boff_d        = boff_q;
    pc_d          = pc_q;
    out_valid_d   = 1'b0;
    wb_en_d       = 1'b0;
    take_branch_d = 1'b0;
    fault_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          // An op accepted while a taken branch is visible sits in the shadow slot
          rd_d   = take_branch_q ? 5'd0 : rd_i;
          boff_d = branch_offset_i;
          pc_d   = PC_i;
          if (take_branch_q) begin
            out_valid_d = 1'b1;
          end else if (load | store) begin
            if (misalign_c) begin
              out_valid_d = 1'b1;
              fault_d     = 1'b1;
            end else begin
              state_d  = ST_ADDR;
              htrans_d = HTRANS_NONSEQ;
              haddr_d  = address;
              hsize_d  = 3'({1'b0, funct3[1:0]});
              hwrite_d = store & ~load;
              f3_d     = funct3;
              wb_d     = write_back;
              sdata_d  = store_data;
            end
          end else begin
            out_valid_d   = 1'b1;
            res_d         = alu_res;
            wb_en_d       = write_back;
            take_branch_d = branch_flag_i & (alu_res == XLEN'(1));
          end
        end
      end
      ST_ADDR: begin
        if (ahb.HREADY) begin
          state_d  = ST_DATA;
          htrans_d = HTRANS_IDLE;
          if (hwrite_q) hwdata_d = wdata_c;
        end
      end
      ST_DATA: begin
        if (ahb.HREADY) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
          if (ahb.HRESP) begin
            fault_d = 1'b1;
          end else if (!hwrite_q) begin
            res_d   = XLEN'(ld_data_c);
            wb_en_d = wb_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops the bus to IDLE immediately
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= ST_IDLE;
      htrans_q      <= HTRANS_IDLE;
      haddr_q       <= '0;
      hsize_q       <= '0;
      hwrite_q      <= 1'b0;
      hwdata_q      <= '0;
      f3_q          <= '0;
      wb_q          <= 1'b0;
      sdata_q       <= '0;
      out_valid_q   <= 1'b0;
      res_q         <= '0;
      rd_q          <= '0;
      wb_en_q       <= 1'b0;
      take_branch_q <= 1'b0;
      boff_q        <= '0;
      pc_q          <= '0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      htrans_q      <= htrans_d;
      haddr_q       <= haddr_d;
      hsize_q       <= hsize_d;
      hwrite_q      <= hwrite_d;
      hwdata_q      <= hwdata_d;
      f3_q          <= f3_d;
      wb_q          <= wb_d;
      sdata_q       <= sdata_d;
      out_valid_q   <= out_valid_d;
      res_q         <= res_d;
      rd_q          <= rd_d;
      wb_en_q       <= wb_en_d;
      take_branch_q <= take_branch_d;
      boff_q        <= boff_d;
      pc_q          <= pc_d;
      fault_q       <= fault_d;
    end
  end

  assign ahb.HADDR       = haddr_q;
  assign ahb.HWDATA      = hwdata_q;
  assign ahb.HWRITE      = hwrite_q;
  assign ahb.HTRANS      = htrans_q;
  assign ahb.HSIZE       = hsize_q;
  assign out_valid       = out_valid_q;
  assign res             = res_q;
  assign rd_o            = rd_q;
  assign wb_en           = wb_en_q;
  assign take_branch     = take_branch_q;
  assign branch_offset_o = boff_q;
  assign PC_o            = pc_q;
  assign fault           = fault_q;

endmodule

// File: tb/tb_mem_stage_ahb.sv
// Randomised bench for mem_stage_ahb against a transaction-level model.
// Honours MEM_MISALIGN_TRAP_EN when the build defines it.
module tb_mem_stage_ahb;
  import mem_pkg::*;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rd_i;
  logic [63:0] address;
  logic [2:0]  funct3;
  logic        load;
  logic        store;
  logic [63:0] store_data;
  logic [63:0] alu_res;
  logic        write_back;
  logic        branch_flag_i;
  logic [63:0] branch_offset_i;
  logic [63:0] PC_i;
  logic        out_valid;
  logic [63:0] res;
  logic [4:0]  rd_o;
  logic        wb_en;
  logic        take_branch;
  logic [63:0] branch_offset_o;
  logic [63:0] PC_o;
  logic        fault;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] res_m = 64'd0;
  bit          tb_m  = 1'b0;

  mem_stage_ahb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ahb ();

  mem_stage_ahb #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .rd_i            (rd_i),
    .address         (address),
    .funct3          (funct3),
    .load            (load),
    .store           (store),
    .store_data      (store_data),
    .alu_res         (alu_res),
    .write_back      (write_back),
    .branch_flag_i   (branch_flag_i),
    .branch_offset_i (branch_offset_i),
    .PC_i            (PC_i),
    .ahb             (ahb),
    .out_valid       (out_valid),
    .res             (res),
    .rd_o            (rd_o),
    .wb_en           (wb_en),
    .take_branch     (take_branch),
    .branch_offset_o (branch_offset_o),
    .PC_o            (PC_o),
    .fault           (fault)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected load result from the spec's byte-lane rules
  function automatic logic [63:0] model_load(input logic [63:0] rdata, input logic [63:0] addr,
                                             input logic [2:0] f3);
    logic [63:0] v;
    int nb, off;
    nb  = 1 << f3[1:0];
    off = int'(addr[2:0]);
    v   = 64'd0;
    for (int k = 0; k < nb; k++) v[k*8 +: 8] = rdata[((off + k) % 8)*8 +: 8];
    if (nb < 8 && !f3[2] && v[nb*8-1]) v = v | (~64'd0 << (nb*8));
    return v;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] sd, input logic [2:0] f3);
    logic [63:0] v;
    int nb;
    nb = 1 << f3[1:0];
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = sd[(i % nb)*8 +: 8];
    return v;
  endfunction

  // Issue one op, play the AHB slave with the given wait states, check everything
  task automatic do_op(input bit b2b, input logic [4:0] rd, input logic [63:0] addr,
                       input logic [2:0] f3, input bit ld, input bit st, input logic [63:0] sd,
                       input logic [63:0] alu, input bit wb, input bit br, input logic [63:0] boff,
                       input logic [63:0] pc, input int aw, input int dw,
                       input logic [63:0] rdata, input bit err);
    bit squash, mem, mis, taken;
    int nb;
    logic [63:0] exp_wd;
    if (!b2b) begin
      in_valid = 1'b0;
      @(negedge CLK);
      chk("idle_out_valid", 64'(out_valid), 64'd0);
      chk("idle_take_branch", 64'(take_branch), 64'd0);
      tb_m = 1'b0;
    end
    squash = tb_m;
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    rd_i = rd; address = addr; funct3 = f3; load = ld; store = st; store_data = sd;
    alu_res = alu; write_back = wb; branch_flag_i = br; branch_offset_i = boff; PC_i = pc;
    in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    mem = (ld | st) && !squash;
    nb  = 1 << f3[1:0];
    mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = mem && ((int'(addr[2:0]) % nb) != 0);
`endif
    chk("pc_o", PC_o, pc);
    chk("branch_offset_o", branch_offset_o, boff);
    if (mem && !mis) begin
      exp_wd = model_wdata(sd, f3);
      chk("addr_htrans", 64'(ahb.HTRANS), 64'(HTRANS_NONSEQ));
      chk("addr_haddr", ahb.HADDR, addr);
      chk("addr_hsize", 64'(ahb.HSIZE), 64'(f3[1:0]));
      chk("addr_hwrite", 64'(ahb.HWRITE), 64'(st & !ld));
      chk("addr_in_ready", 64'(in_ready), 64'd0);
      for (int w = 0; w <= aw; w++) begin
        ahb.HREADY = (w == aw);
        @(negedge CLK);
        if (w < aw) chk("addr_hold_htrans", 64'(ahb.HTRANS), 64'(HTRANS_NONSEQ));
      end
      ahb.HRDATA = rdata;
      for (int w = 0; w <= dw; w++) begin
        chk("data_htrans", 64'(ahb.HTRANS), 64'(HTRANS_IDLE));
        chk("data_haddr", ahb.HADDR, addr);
        chk("data_in_ready", 64'(in_ready), 64'd0);
        chk("data_out_valid", 64'(out_valid), 64'd0);
        if (st && !ld) chk("data_hwdata", ahb.HWDATA, exp_wd);
        ahb.HREADY = (w == dw);
        ahb.HRESP  = err && (w == dw);
        @(negedge CLK);
      end
      ahb.HREADY = 1'b1;
      ahb.HRESP  = 1'b0;
      chk("mem_out_valid", 64'(out_valid), 64'd1);
      chk("mem_fault", 64'(fault), 64'(err));
      chk("mem_wb_en", 64'(wb_en), 64'(ld && wb && !err));
      chk("mem_rd_o", 64'(rd_o), 64'(rd));
      chk("mem_take_branch", 64'(take_branch), 64'd0);
      if (ld && !err) res_m = model_load(rdata, addr, f3);
      if (ld || err) chk("mem_res", res, res_m);
      tb_m = 1'b0;
    end else begin
      taken = !squash && !(ld | st) && br && (alu == 64'd1);
      chk("op_out_valid", 64'(out_valid), 64'd1);
      chk("op_htrans", 64'(ahb.HTRANS), 64'(HTRANS_IDLE));
      chk("op_fault", 64'(fault), 64'(mis));
      chk("op_wb_en", 64'(wb_en), 64'(!squash && !(ld | st) && wb));
      chk("op_rd_o", 64'(rd_o), squash ? 64'd0 : 64'(rd));
      chk("op_take_branch", 64'(take_branch), 64'(taken));
      chk("op_in_ready", 64'(in_ready), 64'd1);
      if (!squash && !(ld | st)) begin
        res_m = alu;
        chk("alu_res", res, res_m);
      end
      tb_m = taken;
    end
  endtask

  initial begin
    bit          kb2b, kld, kst, kbr, kerr;
    int          kind;
    logic [2:0]  kf3;
    logic [63:0] kalu;

    RST_N = 1'b0; in_valid = 1'b0; rd_i = '0; address = '0; funct3 = '0; load = 1'b0;
    store = 1'b0; store_data = '0; alu_res = '0; write_back = 1'b0; branch_flag_i = 1'b0;
    branch_offset_i = '0; PC_i = '0;
    ahb.HRDATA = '0; ahb.HREADY = 1'b1; ahb.HRESP = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_res", res, 64'd0);
    chk("rst_rd_o", 64'(rd_o), 64'd0);
    chk("rst_wb_en", 64'(wb_en), 64'd0);
    chk("rst_take_branch", 64'(take_branch), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_htrans", 64'(ahb.HTRANS), 64'(HTRANS_IDLE));
    chk("rst_haddr", ahb.HADDR, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // Directed cases
    do_op(0, 5'd5, 64'h0, 3'd0, 0, 0, 64'h0, 64'h1234, 1, 0, 64'h40, 64'h100, 0, 0, 64'h0, 0);
    chk("tp_alu_res", res, 64'h1234);
    do_op(0, 5'd6, 64'h1003, F3_LB, 1, 0, 64'h0, 64'h0, 1, 0, 64'h0, 64'h104, 0, 0,
          64'h00000000_80000000, 0);
    chk("tp_lb_res", res, 64'hFFFF_FFFF_FFFF_FF80);
    do_op(1, 5'd7, 64'h1004, F3_LWU, 1, 0, 64'h0, 64'h0, 1, 0, 64'h0, 64'h108, 0, 3,
          64'h89ABCDEF_01234567, 0);
    chk("tp_lwu_res", res, 64'h0000_0000_89AB_CDEF);
    do_op(0, 5'd8, 64'h2002, F3_LH, 0, 1, 64'hBEEF, 64'h0, 1, 0, 64'h0, 64'h10C, 1, 1,
          64'h0, 0);
    do_op(0, 5'd9, 64'h0, 3'd0, 0, 0, 64'h0, 64'd1, 1, 1, 64'h80, 64'h110, 0, 0, 64'h0, 0);
    chk("tp_branch_taken", 64'(take_branch), 64'd1);
    do_op(1, 5'd10, 64'h3000, F3_LD, 1, 0, 64'h0, 64'h0, 1, 0, 64'h0, 64'h114, 0, 0,
          64'h1122334455667788, 0);
    do_op(0, 5'd11, 64'h1008, F3_LW, 1, 0, 64'h0, 64'h0, 1, 0, 64'h0, 64'h118, 0, 1,
          64'hDEADBEEF_CAFEF00D, 1);
    do_op(0, 5'd12, 64'h1002, F3_LW, 1, 0, 64'h0, 64'h0, 1, 0, 64'h0, 64'h11C, 0, 0,
          64'h0706050403020100, 0);
    do_op(0, 5'd13, 64'h1005, F3_LD, 1, 1, 64'h55, 64'h0, 1, 0, 64'h0, 64'h120, 0, 0,
          64'h0706050403020100, 0);

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 3);
      kld  = (kind == 1) || (kind == 3);
      kst  = (kind == 2) || (kind == 3);
      kbr  = (kind == 0) && ($urandom_range(0, 2) == 0);
      kf3  = 3'($urandom_range(0, 7));
      if (kf3[1:0] == 2'd3) kf3[2] = 1'b0;
      kalu = kbr ? 64'($urandom_range(0, 1)) : {$urandom, $urandom};
      kerr = (kind != 0) && ($urandom_range(0, 7) == 0);
      kb2b = $urandom_range(0, 1) == 1;
      do_op(kb2b, 5'($urandom), {$urandom, $urandom}, kf3, kld, kst, {$urandom, $urandom},
            kalu, 1'($urandom), kbr, {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 2), $urandom_range(0, 3), {$urandom, $urandom}, kerr);
    end

    // Reset during an address phase abandons the transfer at once
    in_valid = 1'b0;
    @(negedge CLK);
    rd_i = 5'd3; address = 64'h4000; funct3 = F3_LD; load = 1'b1; store = 1'b0;
    branch_flag_i = 1'b0; in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    ahb.HREADY = 1'b0;
    chk("mid_rst_pre_htrans", 64'(ahb.HTRANS), 64'(HTRANS_NONSEQ));
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst_htrans", 64'(ahb.HTRANS), 64'(HTRANS_IDLE));
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    ahb.HREADY = 1'b1;
    @(negedge CLK);
    RST_N = 1'b1;
    res_m = 64'd0;
    tb_m  = 1'b0;
    do_op(0, 5'd4, 64'h0, 3'd0, 0, 0, 64'h0, 64'hABCD, 1, 0, 64'h0, 64'h200, 0, 0, 64'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
